// File: rtl/mem_access_stage.sv
// Memory-access stage: byte/half/word loads and stores over a valid/ready
// data-memory port, with fault and timeout reporting toward write-back.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   ex_valid, ALUResult,  instruction from execute (address / pass value,
//   WriteData, MemRead,   store data, op type, access size)
//   MemWrite, funct3
//   stall                 hold upstream while a transfer is pending
//   mem_req/we/addr/      registered request to data memory
//   wdata/wstrb
//   mem_ready, mem_rdata  memory handshake and read data
//   result_valid,         one-cycle result pulse with registered
//   ALUResultOut,         pass-through value, extended load data,
//   ReadData, fault,      and fault / timeout flags
//   timeout_err
module mem_access_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        result_valid,
    output logic [31:0] ALUResultOut,
    output logic [31:0] ReadData,
    output logic        fault,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_addr;

    logic        w_mem_op, w_legal, w_aligned;
    logic        w_start, w_fault, w_pass, w_done_ok, w_timeout;
    logic [31:0] w_wdata, w_load;
    logic [3:0]  w_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_mem_op = ex_valid & (MemRead | MemWrite);

    // Legality, alignment and store lane formatting from the live inputs
    always_comb begin
        w_legal   = 1'b0;
        w_aligned = 1'b1;
        w_wdata   = 32'h0;
        w_wstrb   = 4'h0;
        if (MemWrite)
            w_legal = (funct3 <= 3'b010);
        else
            w_legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
        case (funct3[1:0])
            2'b01:   w_aligned = ~ALUResult[0];
            2'b10:   w_aligned = (ALUResult[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
        if (MemWrite) begin
            case (funct3[1:0])
                2'b00: begin
                    w_wdata = {4{WriteData[7:0]}};
                    w_wstrb = 4'b0001 << ALUResult[1:0];
                end
                2'b01: begin
                    w_wdata = {2{WriteData[15:0]}};
                    w_wstrb = 4'b0011 << ALUResult[1:0];
                end
                default: begin
                    w_wdata = WriteData;
                    w_wstrb = 4'b1111;
                end
            endcase
        end
    end

    // Lane selection and extension of returned load data
    always_comb begin
        case (r_off)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_fault   = 1'b0;
        w_pass    = 1'b0;
        w_done_ok = 1'b0;
        w_timeout = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_mem_op) begin
                    if (w_legal && w_aligned) begin
                        w_start = 1'b1;
                        w_next  = BUSY;
                    end else begin
                        w_fault = 1'b1;
                        w_next  = DONE;
                    end
                end else if (ex_valid) begin
                    w_pass = 1'b1;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    w_done_ok = 1'b1;
                    w_next    = DONE;
                end else if (r_cnt == LP_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign stall = ((r_state == IDLE) & w_mem_op) | (r_state == BUSY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= 8'h0;
            r_funct3     <= 3'h0;
            r_off        <= 2'h0;
            r_addr       <= 32'h0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            mem_wstrb    <= 4'h0;
            result_valid <= 1'b0;
            ALUResultOut <= 32'h0;
            ReadData     <= 32'h0;
            fault        <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            fault        <= 1'b0;
            timeout_err  <= 1'b0;
            if (w_start)
                r_cnt <= 8'h0;
            else if (r_state == BUSY)
                r_cnt <= r_cnt + 8'h1;
            if (w_start) begin
                mem_req   <= 1'b1;
                mem_we    <= MemWrite;
                mem_addr  <= {ALUResult[31:2], 2'b00};
                mem_wdata <= w_wdata;
                mem_wstrb <= w_wstrb;
                r_funct3  <= funct3;
                r_off     <= ALUResult[1:0];
                r_addr    <= ALUResult;
            end
            if (w_pass || w_fault) begin
                result_valid <= 1'b1;
                fault        <= w_fault;
                ALUResultOut <= ALUResult;
                ReadData     <= 32'h0;
            end
            if (w_done_ok || w_timeout) begin
                mem_req      <= 1'b0;
                result_valid <= 1'b1;
                timeout_err  <= w_timeout;
                ALUResultOut <= r_addr;
                // Stores and aborted transfers return no data
                ReadData     <= (w_done_ok && !mem_we) ? w_load : 32'h0;
            end
        end
    end

endmodule
